isp_dpc_ctrl: RTL and testbench
===============================

# isp_dpc_ctrl

Frame-level controller for the defective-pixel-correction stage. It shadows host configuration (threshold, enable) and commits it only at frame boundaries. It tracks frame geometry from `in_href`/`in_vsync`, waits out the correction pipeline latency, and reports frame completion and geometry errors. It sits beside the DPC datapath on the same pixel clock, driving its threshold and the downstream bypass select.

## Interface
- `WIDTH`, 1280: expected active pixels per line.
- `HEIGHT`, 960: expected lines per frame.
- `BITS`, 8: pixel/threshold width.
- `LAT`, 10: DPC pipeline latency in pclk cycles (drain length).
- `THRESH_RST`, 8'd32: `dpc_threshold` reset value.
- `pclk`  in  1  pixel clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_href`  in  1  line valid, same signal that feeds DPC.
- `in_vsync`  in  1  frame sync, high during vertical blanking.
- `cfg_valid`  in  1  host config request.
- `cfg_ready`  out  1  pending slot empty; transfer on `cfg_valid & cfg_ready`.
- `cfg_threshold`  in  BITS  requested threshold.
- `cfg_enable`  in  1  requested correction enable (0 = bypass).
- `err_clr`  in  1  clears sticky error flags.
- `dpc_threshold`  out  BITS  active threshold to DPC.
- `dpc_enable`  out  1  active enable to the bypass mux.
- `cfg_applied`  out  1  one-cycle pulse when pending config is committed.
- `frame_done`  out  1  one-cycle pulse after the last corrected pixel exits DPC.
- `frame_cnt`  out  16  completed frames, wraps 0xFFFF→0.
- `err_width`  out  1  sticky; some line length ≠ WIDTH.
- `err_height`  out  1  sticky; frame line count ≠ HEIGHT.
- `busy`  out  1  state is ACTIVE or DRAIN.

## Operation
- Edges are detected against 1-cycle registered copies `vs_r`/`hr_r`.
  - vsync rise = `in_vsync & ~vs_r`; vsync fall = `~in_vsync & vs_r`.
  - href fall = `~in_href & hr_r`; href rise = `in_href & ~hr_r`.
- Config path:
  - `cfg_ready = ~pend`.
  - On accept: latch value into pending registers, set `pend`.
  - On vsync rise with `pend`: copy pending to active, clear `pend`, pulse `cfg_applied`.
  - Because a transfer requires `~pend`, an accept and a commit never occur in the same cycle. A value accepted in the vsync-rise cycle waits for the next frame.
- Pixel counter `pix_cnt` (clog2(WIDTH+1) bits) increments each cycle with `in_href=1`, saturating at all-ones.
  - On href fall: compare against WIDTH, then clear.
- Line counter `line_cnt` increments on href fall.
  - It clears on vsync rise.
- FSM, 2-bit:
  - IDLE (reset): on vsync rise → VBLANK.
  - VBLANK: on vsync fall → ACTIVE.
  - ACTIVE: if href fall makes `line_cnt+1 == HEIGHT` → DRAIN, loading `drain_cnt = LAT`.
    - A vsync rise in ACTIVE (short frame) sets `err_height` → VBLANK. No `frame_done`, `frame_cnt` unchanged.
  - DRAIN: `drain_cnt` decrements each cycle. When it reaches 0: pulse `frame_done`, increment `frame_cnt`, → IDLE.
    - href rise in DRAIN or IDLE (extra line) sets `err_height`.
    - vsync rise in DRAIN still completes the drain, then IDLE accepts the next vsync rise once `in_vsync` has fallen and risen again. The committing vsync rise is honoured regardless of state.
- Error flags:
  - `err_width` sets on href fall with `pix_cnt != WIDTH`.
  - Both flags clear on `err_clr`. A new error in the same cycle wins (flag stays 1).

## Timing
- All outputs are registered.
- Reset values:
  - `dpc_threshold=THRESH_RST`, `dpc_enable=0`, `cfg_ready=1`.
  - All pulses, errors, `busy` = 0; `frame_cnt=0`.
  - Pending registers cleared; FSM IDLE.
- Committed config is visible 1 cycle after the cycle where `in_vsync` first samples high.
- `frame_done` is asserted LAT+1 cycles after the cycle in which the last href fall is sampled.
- `cfg_ready` returns high 1 cycle after `cfg_applied`.
- `rst` mid-frame: all state, including any pending config, returns to reset values immediately (asynchronous). The frame in progress is not reported.

## Structure
- Shared package `isp_dpc_pkg`:
  - FSM state encodings (IDLE=0, VBLANK=1, ACTIVE=2, DRAIN=3).
  - `FRAME_CNT_W=16`.
  - Common clog2 function.
- One sub-module, `isp_frame_monitor`: edge detection, pixel/line counters, width check. The top holds the FSM, config shadowing and drain.

## Test plan
- Reset with `rst=1` → `dpc_threshold=32`, `dpc_enable=0`, `cfg_ready=1`, all flags/pulses 0, `frame_cnt=0`.
- WIDTH=8, HEIGHT=4, LAT=10; write threshold 20 / enable 1 mid-frame → `cfg_ready` drops. Outputs unchanged until next vsync rise, then 20/1 one cycle later with a `cfg_applied` pulse, and `cfg_ready=1` the cycle after.
- Nominal frame of 4×8 pixels → `frame_done` exactly 11 cycles after the last href fall, `frame_cnt=1`, no errors.
- Line of 7 pixels → `err_width=1` after that line, held across frames; `err_clr` clears it. An `err_clr` coinciding with another bad line keeps it at 1.
- vsync rise after 3 lines → `err_height=1`, no `frame_done`, `frame_cnt` unchanged; a following good frame completes normally.
- `rst` pulse during ACTIVE with config pending → all reset values; the pending threshold is never applied.

Source files
------------

// File: rtl/isp_dpc_pkg.sv
// Shared definitions for the defective-pixel-correction frame controller.
package isp_dpc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } dpc_state_t;

    localparam int FRAME_CNT_W = 16;

    // Minimum bit count able to hold values 0 .. value-1 (never less than 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/isp_frame_monitor.sv
// Sync edge detection, pixel/line counting and line-length check for one frame.
module isp_frame_monitor
    import isp_dpc_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic pclk,
    input  logic rst,
    input  logic i_href,
    input  logic i_vsync,
    output logic o_vs_rise,
    output logic o_vs_fall,
    output logic o_hr_rise,
    output logic o_last_line,
    output logic o_width_bad
);

    localparam int PW = clog2(WIDTH + 1);
    // One spare code so an over-long frame cannot alias onto the last line.
    localparam int LW = clog2(HEIGHT + 2);
    localparam logic [PW-1:0] PIX_EXP   = PW'(WIDTH);
    localparam logic [LW-1:0] LINE_LAST = LW'(HEIGHT - 1);

    logic          r_vs;
    logic          r_hr;
    logic [PW-1:0] r_pix;
    logic [LW-1:0] r_line;
    logic          w_hr_fall;

    assign o_vs_rise   = i_vsync & ~r_vs;
    assign o_vs_fall   = ~i_vsync & r_vs;
    assign o_hr_rise   = i_href & ~r_hr;
    assign w_hr_fall   = ~i_href & r_hr;
    assign o_last_line = w_hr_fall & (r_line == LINE_LAST);
    assign o_width_bad = w_hr_fall & (r_pix != PIX_EXP);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vs   <= 1'b0;
            r_hr   <= 1'b0;
            r_pix  <= '0;
            r_line <= '0;
        end else begin
            r_vs <= i_vsync;
            r_hr <= i_href;
            if (w_hr_fall)
                r_pix <= '0;
            else if (i_href && (r_pix != '1))
                r_pix <= r_pix + 1'b1;
            if (o_vs_rise)
                r_line <= '0;
            else if (w_hr_fall && (r_line != '1))
                r_line <= r_line + 1'b1;
        end
    end

endmodule

// File: rtl/isp_dpc_ctrl.sv
// Frame-level controller for DPC: config shadowing, frame FSM with pipeline drain, error flags.
//   state  | meaning
//   IDLE   | between frames, waiting for vsync rise
//   VBLANK | vertical blanking, waiting for vsync fall
//   ACTIVE | counting lines of the frame
//   DRAIN  | last line in, waiting LAT cycles for the DPC pipeline to empty
module isp_dpc_ctrl
    import isp_dpc_pkg::*;
#(
    parameter int              WIDTH      = 1280,
    parameter int              HEIGHT     = 960,
    parameter int              BITS       = 8,
    parameter int              LAT        = 10,
    parameter logic [BITS-1:0] THRESH_RST = BITS'(32)
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   in_href,
    input  logic                   in_vsync,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [BITS-1:0]        cfg_threshold,
    input  logic                   cfg_enable,
    input  logic                   err_clr,
    output logic [BITS-1:0]        dpc_threshold,
    output logic                   dpc_enable,
    output logic                   cfg_applied,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_width,
    output logic                   err_height,
    output logic                   busy
);

    localparam int DW = clog2(LAT + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(LAT);

    logic w_vs_rise, w_vs_fall, w_hr_rise, w_last_line, w_width_bad;

    isp_frame_monitor #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_mon (
        .pclk       (pclk),
        .rst        (rst),
        .i_href     (in_href),
        .i_vsync    (in_vsync),
        .o_vs_rise  (w_vs_rise),
        .o_vs_fall  (w_vs_fall),
        .o_hr_rise  (w_hr_rise),
        .o_last_line(w_last_line),
        .o_width_bad(w_width_bad)
    );

    dpc_state_t             r_state, w_state_nxt;
    logic [DW-1:0]          r_drain;
    logic                   w_drain_load, w_done, w_height_err;
    logic                   r_pend, r_pend_en, r_ready, r_en, r_applied;
    logic [BITS-1:0]        r_pend_thr, r_thr;
    logic                   r_done, r_err_w, r_err_h, r_busy;
    logic [FRAME_CNT_W-1:0] r_fcnt;
    logic                   w_accept;

    // r_ready implies no pending value, so accept and commit are exclusive.
    assign w_accept = cfg_valid & r_ready;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_load = 1'b0;
        w_done       = 1'b0;
        w_height_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hr_rise) w_height_err = 1'b1;
                if (w_vs_rise) w_state_nxt  = VBLANK;
            end
            VBLANK: begin
                if (w_vs_fall) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (w_vs_rise) begin
                    w_height_err = 1'b1;
                    w_state_nxt  = VBLANK;
                end else if (w_last_line) begin
                    w_drain_load = 1'b1;
                    w_state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hr_rise) w_height_err = 1'b1;
                if (r_drain == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_drain <= '0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
            r_err_w <= 1'b0;
            r_err_h <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_drain_load)
                r_drain <= DRAIN_LOAD;
            else if ((r_state == DRAIN) && (r_drain != '0))
                r_drain <= r_drain - 1'b1;
            r_done <= w_done;
            if (w_done) r_fcnt <= r_fcnt + 1'b1;
            if (w_width_bad)  r_err_w <= 1'b1;
            else if (err_clr) r_err_w <= 1'b0;
            if (w_height_err) r_err_h <= 1'b1;
            else if (err_clr) r_err_h <= 1'b0;
            r_busy <= (w_state_nxt == ACTIVE) || (w_state_nxt == DRAIN);
        end
    end

    // Ready re-opens one cycle after the commit, from the already-cleared pending bit.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_thr <= '0;
            r_pend_en  <= 1'b0;
            r_ready    <= 1'b1;
            r_thr      <= THRESH_RST;
            r_en       <= 1'b0;
            r_applied  <= 1'b0;
        end else begin
            r_applied <= 1'b0;
            if (w_accept) begin
                r_pend     <= 1'b1;
                r_pend_thr <= cfg_threshold;
                r_pend_en  <= cfg_enable;
                r_ready    <= 1'b0;
            end else begin
                r_ready <= ~r_pend;
                if (w_vs_rise && r_pend) begin
                    r_thr     <= r_pend_thr;
                    r_en      <= r_pend_en;
                    r_pend    <= 1'b0;
                    r_applied <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready     = r_ready;
    assign dpc_threshold = r_thr;
    assign dpc_enable    = r_en;
    assign cfg_applied   = r_applied;
    assign frame_done    = r_done;
    assign frame_cnt     = r_fcnt;
    assign err_width     = r_err_w;
    assign err_height    = r_err_h;
    assign busy          = r_busy;

endmodule

// File: tb/tb_isp_dpc_ctrl.sv
// Randomized frame-level bench for isp_dpc_ctrl with a per-frame reference model.
module tb_isp_dpc_ctrl;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int BITS   = 8;
    localparam int LAT    = 10;

    logic            pclk = 1'b0;
    logic            rst = 1'b1;
    logic            in_href = 1'b0;
    logic            in_vsync = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [BITS-1:0] cfg_threshold = '0;
    logic            cfg_enable = 1'b0;
    logic            err_clr = 1'b0;
    logic            cfg_ready;
    logic [BITS-1:0] dpc_threshold;
    logic            dpc_enable;
    logic            cfg_applied;
    logic            frame_done;
    logic [15:0]     frame_cnt;
    logic            err_width;
    logic            err_height;
    logic            busy;

    always #5 pclk = ~pclk;

    isp_dpc_ctrl #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .BITS      (BITS),
        .LAT       (LAT),
        .THRESH_RST(8'd32)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .in_href      (in_href),
        .in_vsync     (in_vsync),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_threshold(cfg_threshold),
        .cfg_enable   (cfg_enable),
        .err_clr      (err_clr),
        .dpc_threshold(dpc_threshold),
        .dpc_enable   (dpc_enable),
        .cfg_applied  (cfg_applied),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .err_width    (err_width),
        .err_height   (err_height),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_applied = 0;
    int done_q[$];

    // Reference model state, updated from the frame-level rules.
    int m_thr  = 32;
    bit m_en   = 1'b0;
    bit m_pend = 1'b0;
    int m_pthr = 0;
    bit m_pen  = 1'b0;
    bit m_err_w = 1'b0;
    bit m_err_h = 1'b0;
    bit m_short = 1'b0;
    int m_fcnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        cyc++;
        #1;
        if (frame_done)  done_q.push_back(cyc);
        if (cfg_applied) n_applied++;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_thr"},   32'(dpc_threshold), 32);
        check_val({tag, "_en"},    32'(dpc_enable), 0);
        check_val({tag, "_rdy"},   32'(cfg_ready), 1);
        check_val({tag, "_appl"},  32'(cfg_applied), 0);
        check_val({tag, "_done"},  32'(frame_done), 0);
        check_val({tag, "_fcnt"},  32'(frame_cnt), 0);
        check_val({tag, "_errw"},  32'(err_width), 0);
        check_val({tag, "_errh"},  32'(err_height), 0);
        check_val({tag, "_busy"},  32'(busy), 0);
    endtask

    task automatic vsync_start();
        in_vsync = 1'b1;
        step();
        if (m_short) m_err_h = 1'b1;
        m_short = 1'b0;
        check_val("applied_at_vs", 32'(cfg_applied), 32'(m_pend));
        if (m_pend) begin
            m_thr  = m_pthr;
            m_en   = m_pen;
            m_pend = 1'b0;
            check_val("thr_commit", 32'(dpc_threshold), 32'(m_thr));
            check_val("en_commit",  32'(dpc_enable), 32'(m_en));
            check_val("rdy_at_apply", 32'(cfg_ready), 0);
            step();
            check_val("rdy_after_apply", 32'(cfg_ready), 1);
            check_val("applied_pulse", 32'(cfg_applied), 0);
        end else begin
            step();
        end
        step();
        in_vsync = 1'b0;
        step();
        step();
    endtask

    task automatic do_frame(input int nlines, input int bad_line, input int clr_line,
                            input bit do_cfg, input int thr, input bit en);
        int  f_cyc;
        int  len;
        int  exp_appl;
        bit  exp_done;
        f_cyc = -1;
        done_q.delete();
        n_applied = 0;
        exp_appl = m_pend ? 1 : 0;
        vsync_start();
        for (int l = 0; l < nlines; l++) begin
            len = WIDTH;
            if (l == bad_line) len = ($urandom_range(0, 1) == 0) ? WIDTH - 1 : WIDTH + 1;
            if (l >= HEIGHT) m_err_h = 1'b1;
            for (int p = 0; p < len; p++) begin
                in_href = 1'b1;
                if (do_cfg && !m_pend && l == 1 && p == 2) begin
                    cfg_valid     = 1'b1;
                    cfg_threshold = BITS'(thr);
                    cfg_enable    = en;
                end
                step();
                if (cfg_valid) begin
                    cfg_valid = 1'b0;
                    m_pend = 1'b1;
                    m_pthr = thr & 8'hFF;
                    m_pen  = en;
                    check_val("rdy_drop", 32'(cfg_ready), 0);
                    check_val("thr_hold", 32'(dpc_threshold), 32'(m_thr));
                    check_val("en_hold",  32'(dpc_enable), 32'(m_en));
                end
                if (l == 0 && p == 0) check_val("busy_active", 32'(busy), 1);
            end
            in_href = 1'b0;
            err_clr = (l == clr_line);
            step();
            err_clr = 1'b0;
            if (l == HEIGHT - 1) f_cyc = cyc;
            if (l == bad_line)       m_err_w = 1'b1;
            else if (l == clr_line)  m_err_w = 1'b0;
            if (l == clr_line)       m_err_h = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
        repeat (LAT + 6) step();

        exp_done = (nlines >= HEIGHT);
        if (exp_done) m_fcnt = (m_fcnt + 1) & 16'hFFFF;
        else          m_short = 1'b1;
        check_val("done_count", 32'(done_q.size()), exp_done ? 32'd1 : 32'd0);
        if (exp_done && done_q.size() > 0)
            check_val("done_latency", 32'(done_q[0] - f_cyc), 32'(LAT + 1));
        check_val("frame_cnt",   32'(frame_cnt), 32'(m_fcnt));
        check_val("err_width",   32'(err_width), 32'(m_err_w));
        check_val("err_height",  32'(err_height), 32'(m_err_h));
        check_val("busy_end",    32'(busy), exp_done ? 32'd0 : 32'd1);
        check_val("thr_end",     32'(dpc_threshold), 32'(m_thr));
        check_val("en_end",      32'(dpc_enable), 32'(m_en));
        check_val("rdy_end",     32'(cfg_ready), m_pend ? 32'd0 : 32'd1);
        check_val("applied_cnt", 32'(n_applied), 32'(exp_appl));
    endtask

    task automatic idle_clear();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err_w = 1'b0;
        m_err_h = 1'b0;
        check_val("clr_errw", 32'(err_width), 0);
        check_val("clr_errh", 32'(err_height), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check_reset_vals("por");
        rst = 1'b0;
        step();

        // Nominal frame carrying a config write, then the frame that commits it.
        do_frame(4, -1, -1, 1'b1, 20, 1'b1);
        do_frame(4, -1, -1, 1'b0, 0, 1'b0);
        // Bad line, held across a clean frame, cleared, then clear colliding with a bad line.
        do_frame(4, 2, -1, 1'b0, 0, 1'b0);
        do_frame(4, -1, -1, 1'b0, 0, 1'b0);
        idle_clear();
        do_frame(4, 1, 1, 1'b0, 0, 1'b0);
        idle_clear();
        // Short frame, detected at the next vsync, which still completes normally.
        do_frame(3, -1, -1, 1'b0, 0, 1'b0);
        do_frame(4, -1, -1, 1'b0, 0, 1'b0);
        idle_clear();
        // Extra line after the last one.
        do_frame(5, -1, -1, 1'b0, 0, 1'b0);
        idle_clear();

        // Reset mid-frame with a pending config that must never be applied.
        in_vsync = 1'b1;
        repeat (3) step();
        in_vsync = 1'b0;
        repeat (2) step();
        in_href = 1'b1;
        repeat (3) step();
        cfg_valid     = 1'b1;
        cfg_threshold = 8'd99;
        cfg_enable    = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_val("rst_pre_rdy", 32'(cfg_ready), 0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        in_href = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        m_thr = 32; m_en = 1'b0; m_pend = 1'b0; m_err_w = 1'b0;
        m_err_h = 1'b0; m_short = 1'b0; m_fcnt = 0;
        do_frame(4, -1, -1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int nl, bl, cl;
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : HEIGHT;
            bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            cl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            do_frame(nl, bl, cl, ($urandom_range(0, 4) < 3), int'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_clear();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
